sar_adc_ctrl: RTL and testbench



---
 rtl/sar_adc_pkg.sv | 17 +
 rtl/sar_phase_timer.sv | 40 ++++
 rtl/sar_adc_ctrl.sv | 142 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
package sar_adc_pkg;

  // Default conversion resolution; equals the DAC input width.
  localparam int SAR_WIDTH = 10;

  // First trial code of every conversion: only the MSB set.
  localparam logic [SAR_WIDTH-1:0] MIDSCALE = {1'b1, {(SAR_WIDTH-1){1'b0}}};

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter. tc is high during the last cycle of a loaded
// interval, so an interval of N cycles is obtained by loading N.
module sar_phase_timer
  import sar_adc_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over counting; the counter rests at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: drives track/hold and the DAC trial code, resolves one
// bit per settle phase MSB-first, and hands results out over valid/ready with
// a sticky overrun flag.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MAX_CYC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH - 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_tc;
  logic             result_load;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] resolved;

  // One timer serves both the sample window and every bit phase.
  sar_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign tmr_en = (state_q != IDLE);

  // Trial code with the current bit kept or dropped by the comparator.
  always_comb begin
    bit_mask = WIDTH'(1) << bit_q;
    resolved = cmp_in ? dac_q : (dac_q & ~bit_mask);
  end

  // Sequencing: IDLE -> SAMPLE -> CONVERT (WIDTH phases) -> IDLE.
  always_comb begin
    state_d     = state_q;
    dac_d       = dac_q;
    bit_d       = bit_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = CNT_W'(SETTLE_CYCLES);
    result_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SAMPLE;
          dac_d    = MID;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SAMPLE_CYCLES);
        end
      end
      SAMPLE: begin
        if (tmr_tc) begin
          state_d  = CONVERT;
          bit_d    = IDX_W'(WIDTH - 1);
          tmr_load = 1'b1;
        end
      end
      CONVERT: begin
        if (tmr_tc) begin
          if (bit_q != '0) begin
            // Commit this bit and put the next lower one on trial.
            dac_d    = resolved | (bit_mask >> 1);
            bit_d    = bit_q - IDX_W'(1);
            tmr_load = 1'b1;
          end else begin
            dac_d       = resolved;
            data_d      = resolved;
            result_load = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake: a fresh result always wins; it overruns only if the old one
  // is still pending and not being taken this cycle. Set beats clear.
  always_comb begin
    valid_d = result_load | (valid_q & ~data_ready);
    ovr_d   = (result_load & valid_q & ~data_ready) | (ovr_q & ~clr_overrun);
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dac_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac_code   = dac_q;
  assign sample     = (state_q == SAMPLE);
  assign busy       = (state_q != IDLE);
  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed and randomized bench for sar_adc_ctrl with an ideal comparator.
module tb_sar_adc_ctrl;

  localparam int W   = 10;
  localparam int S   = 4;
  localparam int T   = 2;
  localparam int LAT = 1 + S + W * T;
  localparam logic [W-1:0] MID = 10'h200;

  logic         clk;
  logic         reset;
  logic         start;
  logic         cmp_in;
  logic [W-1:0] dac_code;
  logic         sample;
  logic         busy;
  logic [W-1:0] data;
  logic         data_valid;
  logic         data_ready;
  logic         overrun;
  logic         clr_overrun;

  logic [W-1:0] vin;
  logic         tie0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_trial [W];
  logic [W-1:0] exp_res;

  sar_adc_ctrl #(
    .WIDTH         (W),
    .SAMPLE_CYCLES (S),
    .SETTLE_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cmp_in      (cmp_in),
    .dac_code    (dac_code),
    .sample      (sample),
    .busy        (busy),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // Ideal comparator, or stuck low when tie0 is set.
  assign cmp_in = tie0 ? 1'b0 : (vin >= dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Binary search: each phase tries the next lower bit on top of what has
  // been kept so far; the ideal comparator keeps it when vin reaches it.
  task automatic build_model(input logic [W-1:0] v, input logic t0);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    code = '0;
    for (int p = 0; p < W; p++) begin
      trial = code | (W'(1) << (W - 1 - p));
      exp_trial[p] = trial;
      if (!t0 && (v >= trial)) code = trial;
    end
    exp_res = code;
  endtask

  // One conversion from a start pulse in the current cycle. rmode: 0 ready
  // low, 1 ready high, 2 ready only in the cycle the result loads.
  task automatic run_conv(input logic [W-1:0] v, input logic t0, input int rmode,
                          input logic exp_ovr, input logic noisy);
    vin = v;
    tie0 = t0;
    build_model(v, t0);
    start = 1'b1;
    data_ready = (rmode == 1);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT) begin
        check($sformatf("busy c%0d", c), busy, 1);
        check($sformatf("sample c%0d", c), sample, (c <= S));
        if (c <= S) check($sformatf("dac_mid c%0d", c), dac_code, MID);
        else check($sformatf("dac_trial c%0d", c), dac_code, exp_trial[(c - S - 1) / T]);
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        data_ready = (rmode == 1) || ((rmode == 2) && (c == LAT - 1));
      end else begin
        check("done_busy", busy, 0);
        check("done_sample", sample, 0);
        check("done_valid", data_valid, 1);
        check("done_data", data, exp_res);
        check("done_dac_hold", dac_code, exp_res);
        check("done_overrun", overrun, exp_ovr);
        start = 1'b0;
        data_ready = (rmode == 1);
      end
    end
  endtask

  // After an accepted result: valid drops, result and final code hold.
  task automatic after_accept();
    tick();
    check("acc_valid", data_valid, 0);
    check("acc_busy", busy, 0);
    check("acc_data", data, exp_res);
    check("acc_dac", dac_code, exp_res);
  endtask

  initial begin
    int rises[$];
    logic prev;
    logic [W-1:0] v;

    reset = 1'b1;
    start = 1'b0;
    vin = '0;
    tie0 = 1'b0;
    data_ready = 1'b0;
    clr_overrun = 1'b0;
    tick();
    tick();
    check("rst_dac", dac_code, 0);
    check("rst_sample", sample, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // Reference conversion of 0x2AB.
    run_conv(10'h2AB, 1'b0, 1, 1'b0, 1'b0);
    check("t1_data_lit", data, 10'h2AB);
    after_accept();

    // Extremes, with ignored start pulses during the conversions.
    run_conv(10'h3FF, 1'b0, 1, 1'b0, 1'b1);
    after_accept();
    run_conv(10'h3FF, 1'b1, 1, 1'b0, 1'b1);
    check("t2_zero_lit", data, 10'h000);
    after_accept();

    // Random inputs.
    for (int k = 0; k < 4; k++) begin
      v = W'($urandom_range(0, 1023));
      run_conv(v, 1'b0, 1, 1'b0, 1'b1);
      after_accept();
    end

    // Backpressure: second result overwrites the first and flags overrun.
    run_conv(10'h155, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", data_valid, 1);
      check("bp_hold_data", data, 10'h155);
    end
    run_conv(10'h0F0, 1'b0, 0, 1'b1, 1'b0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_data", data, 10'h0F0);
    check("clr_valid", data_valid, 1);

    // Acceptance in the same cycle as the next load.
    v = W'($urandom_range(0, 1023));
    run_conv(v, 1'b0, 2, 1'b0, 1'b0);
    tick();
    check("coin_valid", data_valid, 1);
    check("coin_data", data, v);
    check("coin_overrun", overrun, 0);
    data_ready = 1'b1;
    tick();
    check("coin_accept", data_valid, 0);

    // Start held high: one result every LAT cycles.
    vin = 10'h155;
    tie0 = 1'b0;
    start = 1'b1;
    prev = data_valid;
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (data_valid && !prev) begin
        rises.push_back(c);
        check($sformatf("b2b_data c%0d", c), data, 10'h155);
      end
      prev = data_valid;
      start = (c < 100);
    end
    check("b2b_count", rises.size(), 4);
    for (int i = 0; i < rises.size(); i++)
      check($sformatf("b2b_rise%0d", i), rises[i], 25 * (i + 1));
    check("b2b_idle", busy, 0);

    // Abort by reset in the middle of a conversion with a pending result.
    v = W'($urandom_range(1, 1023));
    run_conv(v, 1'b0, 0, 1'b0, 1'b0);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
    end
    check("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sample", sample, 0);
    check("abort_dac", dac_code, 0);
    check("abort_valid", data_valid, 0);
    check("abort_data", data, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_abort_valid", data_valid, 0);
    check("post_abort_busy", busy, 0);
    run_conv(10'h3A5, 1'b0, 1, 1'b0, 1'b0);
    check("abort_then_lit", data, 10'h3A5);
    after_accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
